// File: rtl/pw_verify_ctrl.sv
// Password verification controller for the door lock: checks a submitted keypad
// code, holds the lock open for a tick-timed window and enforces lockout after repeated failures.
module pw_verify_ctrl #(
    parameter int DIGITS       = 4,
    parameter int DIGIT_W      = 4,
    parameter int MAX_TRIES    = 3,
    parameter int UNLOCK_TICKS = 500,
    parameter int LOCK_TICKS   = 3000,
    parameter int TRY_W        = $clog2(MAX_TRIES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [DIGITS*DIGIT_W-1:0] entry,
    input  logic [DIGITS*DIGIT_W-1:0] password,
    input  logic                    submit,
    input  logic                    lock_req,
    output logic                    unlocked,
    output logic                    lockout,
    output logic                    fail,
    output logic                    clr_entry,
    output logic [TRY_W-1:0]        tries_left
);

    localparam int CW    = DIGITS * DIGIT_W;
    localparam int MAX_T = (UNLOCK_TICKS > LOCK_TICKS) ? UNLOCK_TICKS : LOCK_TICKS;
    localparam int CNT_W = $clog2(MAX_T + 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        OPEN,
        LOCKOUT
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  tick_cnt;
    logic [CW-1:0]     code;

    // NOTE: all state and outputs live in one clocked block and use non-blocking
    // assignments, so every read sees the value from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            unlocked   <= 1'b0;
            lockout    <= 1'b0;
            fail       <= 1'b0;
            clr_entry  <= 1'b0;
            tries_left <= TRY_W'(MAX_TRIES);
            tick_cnt   <= '0;
            code       <= '0;
        end else begin
            // Pulse outputs default low; only the CHECK exit raises them.
            fail      <= 1'b0;
            clr_entry <= 1'b0;

            case (state)
                IDLE: begin
                    if (submit) begin
                        code  <= entry;
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    clr_entry <= 1'b1;
                    tick_cnt  <= '0;
                    if (code == password) begin
                        unlocked   <= 1'b1;
                        tries_left <= TRY_W'(MAX_TRIES);
                        state      <= OPEN;
                    end else begin
                        fail       <= 1'b1;
                        tries_left <= tries_left - TRY_W'(1);
                        if (tries_left == TRY_W'(1)) begin
                            lockout <= 1'b1;
                            state   <= LOCKOUT;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end

                OPEN: begin
                    // lock_req wins over a coincident tick.
                    if (lock_req) begin
                        unlocked <= 1'b0;
                        state    <= IDLE;
                    end else if (tick) begin
                        if (tick_cnt == CNT_W'(UNLOCK_TICKS - 1)) begin
                            unlocked <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                end

                LOCKOUT: begin
                    if (tick) begin
                        if (tick_cnt == CNT_W'(LOCK_TICKS - 1)) begin
                            lockout    <= 1'b0;
                            tries_left <= TRY_W'(MAX_TRIES);
                            state      <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pw_verify_ctrl.sv
// Self-checking bench for pw_verify_ctrl: directed scenarios plus random traffic,
// compared every cycle against a behavioural countdown model of the lock.
module tb_pw_verify_ctrl;

    localparam int          MAX_TRIES = 3;
    localparam int          UNLOCK_T  = 5;
    localparam int          LOCK_T    = 10;
    localparam logic [15:0] PW        = 16'h1234;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic [15:0] entry = '0;
    logic [15:0] password = PW;
    logic        submit = 1'b0;
    logic        lock_req = 1'b0;
    logic        unlocked, lockout, fail, clr_entry;
    logic [1:0]  tries_left;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    pw_verify_ctrl #(
        .DIGITS(4), .DIGIT_W(4), .MAX_TRIES(MAX_TRIES),
        .UNLOCK_TICKS(UNLOCK_T), .LOCK_TICKS(LOCK_T)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .entry(entry), .password(password),
        .submit(submit), .lock_req(lock_req), .unlocked(unlocked), .lockout(lockout),
        .fail(fail), .clr_entry(clr_entry), .tries_left(tries_left)
    );

    always #5 clk = ~clk;

    // Reference model: a pending-check flag plus a countdown of ticks still owed.
    bit          m_pending, m_unlocked, m_lockout, m_fail, m_clr;
    int          m_tries, m_remaining;
    logic [15:0] m_code;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_pending = 0; m_unlocked = 0; m_lockout = 0; m_fail = 0; m_clr = 0;
            m_tries = MAX_TRIES; m_remaining = 0; m_code = '0;
        end else begin
            m_fail = 0;
            m_clr  = 0;
            if (m_pending) begin
                m_pending = 0;
                m_clr = 1;
                if (m_code == password) begin
                    m_unlocked = 1; m_tries = MAX_TRIES; m_remaining = UNLOCK_T;
                end else begin
                    m_fail = 1;
                    m_tries = m_tries - 1;
                    if (m_tries == 0) begin
                        m_lockout = 1; m_remaining = LOCK_T;
                    end
                end
            end else if (m_unlocked) begin
                if (lock_req) m_unlocked = 0;
                else if (tick) begin
                    m_remaining--;
                    if (m_remaining == 0) m_unlocked = 0;
                end
            end else if (m_lockout) begin
                if (tick) begin
                    m_remaining--;
                    if (m_remaining == 0) begin
                        m_lockout = 0; m_tries = MAX_TRIES;
                    end
                end
            end else if (submit) begin
                m_pending = 1;
                m_code = entry;
            end
        end
    endtask

    function automatic bit next_tick();
        return (cyc % 4) == 3;
    endfunction

    // One clock: tick strobe every 4 clks, model advance, compare after the edge.
    task automatic step();
        tick = next_tick();
        @(posedge clk);
        model_update();
        #1;
        check("unlocked",   int'(unlocked),   int'(m_unlocked));
        check("lockout",    int'(lockout),    int'(m_lockout));
        check("fail",       int'(fail),       int'(m_fail));
        check("clr_entry",  int'(clr_entry),  int'(m_clr));
        check("tries_left", int'(tries_left), m_tries);
        check("exclusive",  int'(unlocked & lockout), 0);
        cyc++;
        submit   = 1'b0;
        lock_req = 1'b0;
    endtask

    task automatic do_submit(input logic [15:0] code);
        entry  = code;
        submit = 1'b1;
        step();
    endtask

    task automatic wait_closed(input string tag);
        int n = 0;
        while ((m_unlocked || m_lockout || m_pending) && n < 200) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, int'(n < 200), 1);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        check("rst_tries", int'(tries_left), MAX_TRIES);
        check("rst_unl",   int'(unlocked), 0);

        // Correct code opens two edges after submit, closes on 5th tick
        do_submit(PW);
        step();
        check("open_unl", int'(unlocked), 1);
        check("open_clr", int'(clr_entry), 1);
        wait_closed("open");
        check("open_closed", int'(unlocked), 0);

        // Wrong then right
        do_submit(16'h1235); step();
        check("wrong_fail",  int'(fail), 1);
        check("wrong_tries", int'(tries_left), 2);
        do_submit(PW); step();
        check("right_tries", int'(tries_left), 3);
        wait_closed("wr");

        // Lockout after three failures; correct code ignored meanwhile
        for (int i = 0; i < 3; i++) begin
            do_submit(16'hBEEF); step();
        end
        check("lock_on",    int'(lockout), 1);
        check("lock_tries", int'(tries_left), 0);
        do_submit(PW); step(); step();
        check("lock_ign", int'(unlocked), 0);
        wait_closed("lock");
        check("lock_rel_tries", int'(tries_left), 3);

        // Early re-lock: lock_req coincident with a tick
        do_submit(PW); step();
        step();
        while (!next_tick()) step();
        lock_req = 1'b1;
        step();
        check("relock", int'(unlocked), 0);
        step();
        do_submit(PW); step();
        check("reopen", int'(unlocked), 1);
        wait_closed("reopen");

        // Reset after the 4th lockout tick
        for (int i = 0; i < 3; i++) begin
            do_submit(16'h0000); step();
        end
        begin
            int ticks = 0;
            int n = 0;
            while (ticks < 4 && n < 100) begin
                if (next_tick()) ticks++;
                step();
                n++;
            end
        end
        check("rstlk_pre", int'(lockout), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstlk_lock",  int'(lockout), 0);
        check("rstlk_tries", int'(tries_left), 3);
        do_submit(PW); step();
        check("rstlk_open", int'(unlocked), 1);
        wait_closed("rstlk");

        // Submit held for two clocks: only one check
        entry = PW; submit = 1'b1; step();
        submit = 1'b1; step();
        check("coll_unl", int'(unlocked), 1);
        check("coll_clr", int'(clr_entry), 1);
        step();
        check("coll_clr2", int'(clr_entry), 0);
        wait_closed("coll");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            int r = int'($urandom_range(0, 2));
            if (r == 0)      entry = PW;
            else if (r == 1) entry = PW ^ (16'h1 << $urandom_range(0, 15));
            else             entry = 16'($urandom);
            submit   = ($urandom_range(0, 3) == 0);
            lock_req = ($urandom_range(0, 9) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
